// File: rtl/nec_pkg.sv
// Shared definitions for the NEC IR transmitter: FSM state type and
// protocol timing expressed in NEC units.
package nec_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEAD_MARK,
    LEAD_SPACE,
    BIT_MARK,
    BIT_SPACE,
    STOP_MARK,
    GAP
  } nec_state_t;

  localparam int LEAD_MARK_UNITS  = 16;
  localparam int LEAD_SPACE_UNITS = 8;
  localparam int BIT_MARK_UNITS   = 1;
  localparam int ZERO_SPACE_UNITS = 1;
  localparam int ONE_SPACE_UNITS  = 3;
  localparam int STOP_MARK_UNITS  = 1;
  localparam int FRAME_BITS       = 32;

  function automatic logic is_mark(input nec_state_t s);
    return (s == LEAD_MARK) || (s == BIT_MARK) || (s == STOP_MARK);
  endfunction

endpackage

// File: rtl/ir_carrier_gen.sv
// IR carrier generator: phase counter restarted at every mark, so each mark
// begins with the high part of the carrier. Output is for the upcoming cycle.
module ir_carrier_gen #(
  parameter int PERIOD = 658,
  parameter int HIGH   = 219
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  input  logic enable,
  output logic carrier
);

  localparam int CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;

  always_comb begin
    cnt_next = cnt + CW'(1);
    if (restart || (cnt == CW'(PERIOD - 1))) begin
      cnt_next = '0;
    end
  end

  // Gated so nothing toggles outside marks; the counter holds between marks.
  assign carrier = (restart || enable) && (32'(cnt_next) < 32'(HIGH));

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (restart || enable) begin
      cnt <= cnt_next;
    end
  end

endmodule

// File: rtl/nec_tx.sv
// NEC infrared frame transmitter: leader, 32 pulse-distance bits LSB-first,
// stop mark and an enforced inter-frame gap, with optional carrier on marks.
module nec_tx import nec_pkg::*; #(
  parameter int UNIT_CYC       = 14063,
  parameter int CARRIER_PERIOD = 658,
  parameter int CARRIER_HIGH   = 219,
  parameter int MODULATE       = 1,
  parameter int GAP_UNITS      = 72
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] cmd,
  input  logic        valid,
  output logic        ready,
  output logic        ir_output,
  output logic        done
);

  localparam int CW   = (UNIT_CYC > 1) ? $clog2(UNIT_CYC) : 1;
  localparam int MAXU = (GAP_UNITS > LEAD_MARK_UNITS) ? GAP_UNITS : LEAD_MARK_UNITS;
  localparam int UW   = $clog2(MAXU + 1);

  nec_state_t    state;
  nec_state_t    nxt;
  logic [CW-1:0] cyc;
  logic [UW-1:0] unit;
  logic [4:0]    bit_idx;
  logic [31:0]   shreg;
  logic [UW-1:0] phase_units;
  logic          accept;
  logic          unit_end;
  logic          phase_end;
  logic          next_mark;
  logic          mark_start;
  logic          carrier;

  always_comb begin
    phase_units = UW'(1);
    case (state)
      LEAD_MARK:  phase_units = UW'(LEAD_MARK_UNITS);
      LEAD_SPACE: phase_units = UW'(LEAD_SPACE_UNITS);
      BIT_MARK:   phase_units = UW'(BIT_MARK_UNITS);
      BIT_SPACE:  phase_units = shreg[0] ? UW'(ONE_SPACE_UNITS) : UW'(ZERO_SPACE_UNITS);
      STOP_MARK:  phase_units = UW'(STOP_MARK_UNITS);
      GAP:        phase_units = UW'(GAP_UNITS);
      default:    phase_units = UW'(1);
    endcase
  end

  assign accept    = ready && valid;
  assign unit_end  = (state != IDLE) && (cyc == CW'(UNIT_CYC - 1));
  assign phase_end = unit_end && (unit == phase_units - UW'(1));

  always_comb begin
    nxt = state;
    case (state)
      IDLE:       if (accept) nxt = LEAD_MARK;
      LEAD_MARK:  if (phase_end) nxt = LEAD_SPACE;
      LEAD_SPACE: if (phase_end) nxt = BIT_MARK;
      BIT_MARK:   if (phase_end) nxt = BIT_SPACE;
      BIT_SPACE:  if (phase_end) nxt = (bit_idx == 5'(FRAME_BITS - 1)) ? STOP_MARK : BIT_MARK;
      STOP_MARK:  if (phase_end) nxt = GAP;
      GAP:        if (phase_end) nxt = IDLE;
      default:    nxt = IDLE;
    endcase
  end

  // Marks never follow marks, so any entry into a mark state is a mark start.
  assign next_mark  = is_mark(nxt);
  assign mark_start = next_mark && (nxt != state);

  ir_carrier_gen #(
    .PERIOD(CARRIER_PERIOD),
    .HIGH  (CARRIER_HIGH)
  ) u_carrier (
    .clk    (clk),
    .rst    (rst),
    .restart(mark_start),
    .enable (next_mark && !mark_start),
    .carrier(carrier)
  );

  // Outputs are registered from the next-cycle state, so the first leader
  // cycle appears right after the accept edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cyc       <= '0;
      unit      <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      ready     <= 1'b1;
      ir_output <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= nxt;
      ready     <= (nxt == IDLE);
      done      <= (state == GAP) && phase_end;
      ir_output <= next_mark && ((MODULATE != 0) ? carrier : 1'b1);
      if (state == IDLE) begin
        cyc  <= '0;
        unit <= '0;
        if (accept) begin
          shreg   <= cmd;
          bit_idx <= '0;
        end
      end else begin
        if (unit_end) begin
          cyc  <= '0;
          unit <= phase_end ? '0 : unit + UW'(1);
        end else begin
          cyc <= cyc + CW'(1);
        end
        if ((state == BIT_SPACE) && phase_end) begin
          shreg   <= shreg >> 1;
          bit_idx <= bit_idx + 5'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_nec_tx.sv
// Self-checking bench for nec_tx: one unmodulated and one modulated instance
// driven in lock-step, compared against a cycle-level waveform model.
module tb_nec_tx;

  localparam int UNIT   = 4;
  localparam int CPER   = 3;
  localparam int CHIGH  = 1;
  localparam int GAPU   = 72;
  localparam int BUDGET = 2000;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid;
  logic [31:0] cmd;
  logic        ready0, ir0, done0;
  logic        ready1, ir1, done1;

  int n_cmp = 0;
  int n_bad = 0;

  logic exp_plain[$];
  logic exp_mod[$];
  logic cap_plain[$];
  logic cap_mod[$];
  int   cap_len;
  int   cap_side_err;
  logic cap_done;

  typedef struct {
    logic [31:0] c;
    int          low_cycles;
  } vec_t;

  vec_t vecs[5];

  always #5 clk = ~clk;

  nec_tx #(
    .UNIT_CYC(UNIT), .CARRIER_PERIOD(CPER), .CARRIER_HIGH(CHIGH),
    .MODULATE(0), .GAP_UNITS(GAPU)
  ) dut_plain (
    .clk(clk), .rst(rst), .cmd(cmd), .valid(valid),
    .ready(ready0), .ir_output(ir0), .done(done0)
  );

  nec_tx #(
    .UNIT_CYC(UNIT), .CARRIER_PERIOD(CPER), .CARRIER_HIGH(CHIGH),
    .MODULATE(1), .GAP_UNITS(GAPU)
  ) dut_mod (
    .clk(clk), .rst(rst), .cmd(cmd), .valid(valid),
    .ready(ready1), .ir_output(ir1), .done(done1)
  );

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_cmp++;
    if (actual !== expected) begin
      n_bad++;
      $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, actual, expected);
    end
  endtask

  task automatic addPhase(input int units, input logic mark);
    for (int i = 0; i < units * UNIT; i++) begin
      exp_plain.push_back(mark);
      exp_mod.push_back(mark && ((i % CPER) < CHIGH));
    end
  endtask

  task automatic buildModel(input logic [31:0] c);
    exp_plain.delete();
    exp_mod.delete();
    addPhase(16, 1'b1);
    addPhase(8, 1'b0);
    for (int i = 0; i < 32; i++) begin
      addPhase(1, 1'b1);
      addPhase(c[i] ? 3 : 1, 1'b0);
    end
    addPhase(1, 1'b1);
    addPhase(GAPU, 1'b0);
  endtask

  task automatic decodeFrame(output logic [31:0] w, output int lm, output int ls, output int sm);
    int   runs[$];
    int   len;
    logic cur;
    w  = '0;
    lm = -1;
    ls = -1;
    sm = -1;
    if (cap_plain.size() == 0) return;
    if (cap_plain[0] !== 1'b1) runs.push_back(0);
    cur = cap_plain[0];
    len = 0;
    foreach (cap_plain[i]) begin
      if (cap_plain[i] === cur) begin
        len++;
      end else begin
        runs.push_back(len);
        cur = cap_plain[i];
        len = 1;
      end
    end
    runs.push_back(len);
    if (runs.size() < 67) return;
    lm = runs[0];
    ls = runs[1];
    sm = runs[66];
    for (int i = 0; i < 32; i++) w[i] = (runs[3 + 2 * i] > 2 * UNIT);
  endtask

  // Drives a one-cycle valid; returns on the first frame cycle.
  task automatic applyStimulus(input logic [31:0] c);
    cmd   = c;
    valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
  endtask

  // Records both outputs until ready rises, optionally disturbing inputs.
  task automatic captureFrame(input int stim_at, input logic [31:0] stim_cmd, input logic stim_valid);
    cap_plain.delete();
    cap_mod.delete();
    cap_len      = 0;
    cap_side_err = 0;
    while (ready0 !== 1'b1 && cap_len < BUDGET) begin
      cap_plain.push_back(ir0);
      cap_mod.push_back(ir1);
      if (ready1 !== 1'b0 || done0 !== 1'b0 || done1 !== 1'b0) cap_side_err++;
      if (cap_len == stim_at) begin
        cmd   = stim_cmd;
        valid = stim_valid;
      end
      if (stim_at >= 0 && cap_len == stim_at + 1) valid = 1'b0;
      cap_len++;
      @(negedge clk);
    end
    cap_done = (ready1 === 1'b1) && (done0 === 1'b1) && (done1 === 1'b1);
  endtask

  task automatic compareFrame(input string tag, input logic [31:0] c, input int exp_low);
    int          werr_p;
    int          werr_m;
    int          n;
    logic [31:0] w;
    int          lm, ls, sm;
    buildModel(c);
    werr_p = 0;
    werr_m = 0;
    n = (cap_plain.size() > exp_plain.size()) ? cap_plain.size() : exp_plain.size();
    for (int i = 0; i < n; i++) begin
      if (i >= cap_plain.size() || i >= exp_plain.size() || cap_plain[i] !== exp_plain[i]) werr_p++;
      if (i >= cap_mod.size() || i >= exp_mod.size() || cap_mod[i] !== exp_mod[i]) werr_m++;
    end
    decodeFrame(w, lm, ls, sm);
    checkOutput({tag, "_ready_low"}, 64'(cap_len), 64'(exp_low));
    checkOutput({tag, "_wave_plain_errs"}, 64'(werr_p), 64'd0);
    checkOutput({tag, "_wave_mod_errs"}, 64'(werr_m), 64'd0);
    checkOutput({tag, "_side_errs"}, 64'(cap_side_err), 64'd0);
    checkOutput({tag, "_decoded"}, 64'(w), 64'(c));
    checkOutput({tag, "_lead_mark"}, 64'(lm), 64'd64);
    checkOutput({tag, "_lead_space"}, 64'(ls), 64'd32);
    checkOutput({tag, "_stop_mark"}, 64'(sm), 64'd4);
    checkOutput({tag, "_done_at_ready"}, 64'(cap_done), 64'd1);
  endtask

  task automatic idleCheck(input int cycles, input string tag);
    int bad;
    bad = 0;
    repeat (cycles) begin
      if (ready0 !== 1'b1 || ready1 !== 1'b1 || ir0 !== 1'b0 || ir1 !== 1'b0 ||
          done0 !== 1'b0 || done1 !== 1'b0) bad++;
      @(negedge clk);
    end
    checkOutput(tag, 64'(bad), 64'd0);
  endtask

  task automatic runVector(input vec_t v);
    applyStimulus(v.c);
    captureFrame(-1, 32'h0, 1'b0);
    compareFrame($sformatf("vec_%08h", v.c), v.c, v.low_cycles);
    @(negedge clk);
    checkOutput("done_clears", {62'd0, done0, done1}, 64'd0);
  endtask

  initial begin
    // Ready-low cycles = (89 + 2*ones + 72) * 4, computed by hand.
    vecs[0] = '{32'h9D620707, 756};
    vecs[1] = '{32'h00000000, 644};
    vecs[2] = '{32'hFFFFFFFF, 900};
    vecs[3] = '{32'h00000001, 652};
    vecs[4] = '{32'h80000000, 652};

    rst   = 1'b1;
    valid = 1'b0;
    cmd   = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checkOutput("reset_ready", {62'd0, ready0, ready1}, 64'd3);
    checkOutput("reset_ir", {62'd0, ir0, ir1}, 64'd0);
    checkOutput("reset_done", {62'd0, done0, done1}, 64'd0);
    idleCheck(20, "idle_after_reset");

    foreach (vecs[i]) runVector(vecs[i]);

    // valid during a frame is dropped, and a changed cmd has no effect.
    applyStimulus(32'h9D620707);
    captureFrame(100, 32'h12345678, 1'b1);
    compareFrame("ignore", 32'h9D620707, 756);
    @(negedge clk);
    idleCheck(30, "no_second_frame");

    // valid held: the next frame starts on the cycle ready rises.
    cmd   = 32'h0;
    valid = 1'b1;
    @(negedge clk);
    captureFrame(-1, 32'h0, 1'b1);
    compareFrame("b2b_first", 32'h0, 644);
    @(negedge clk);
    checkOutput("b2b_ready_drop", {63'd0, ready0}, 64'd0);
    captureFrame(0, 32'h0, 1'b0);
    compareFrame("b2b_second", 32'h0, 644);
    @(negedge clk);
    idleCheck(20, "b2b_idle_after");

    // Reset during bit 10's space (frame cycles 220..231 for this command).
    applyStimulus(32'h9D620707);
    repeat (224) @(negedge clk);
    checkOutput("pre_reset_state", {62'd0, ready0, ir0}, 64'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("abort_ready", {62'd0, ready0, ready1}, 64'd3);
    checkOutput("abort_ir_done", {60'd0, ir0, ir1, done0, done1}, 64'd0);
    idleCheck(20, "abort_idle");
    runVector(vecs[0]);

    // Reset asserted together with valid: nothing accepted.
    cmd   = 32'hFFFFFFFF;
    rst   = 1'b1;
    valid = 1'b1;
    @(negedge clk);
    rst   = 1'b0;
    valid = 1'b0;
    idleCheck(10, "rst_beats_valid");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/nec_tx.md
# nec_tx

NEC-protocol infrared frame transmitter that sits directly downstream of the key-to-command stage in the IR remote design. Accepts a 32-bit command word through a valid/ready handshake and serialises it onto a single IR output pin: leader, 32 pulse-distance bits LSB-first, stop mark, then an enforced inter-frame gap. Optionally modulates marks with a 38 kHz carrier so the pin can drive an IR LED directly. The `ready` output doubles as the board's "transmitter idle" LED.

## Interface
- `UNIT_CYC`, 14063: clock cycles per NEC unit (562.5 µs at 25 MHz).
- `CARRIER_PERIOD`, 658: carrier period in cycles (≈38 kHz at 25 MHz).
- `CARRIER_HIGH`, 219: carrier high cycles per period (≈1/3 duty).
- `MODULATE`, 1: 1 = marks carry carrier; 0 = marks are steady high.
- `GAP_UNITS`, 72: idle units enforced after the stop mark before `ready` returns.

- `clk`  in  1  system clock (25 MHz on board).
- `rst`  in  1  synchronous, active-high reset.
- `cmd`  in  32  command word; `cmd[0]` transmitted first.
- `valid`  in  1  command-valid; sampled only while `ready` = 1.
- `ready`  out  1  high when idle and able to accept a command.
- `ir_output`  out  1  IR pin drive (registered).
- `done`  out  1  one-cycle pulse when a frame, including its gap, completes.

## Operation
- States: IDLE, LEAD_MARK (16 units), LEAD_SPACE (8 units), BIT_MARK (1 unit), BIT_SPACE (1 unit for bit 0, 3 units for bit 1), STOP_MARK (1 unit), GAP (`GAP_UNITS` units).
- IDLE: `ready` = 1, `ir_output` = 0. On `valid && ready`, latch `cmd` into a shift register, clear bit index, go to LEAD_MARK.
- After LEAD_SPACE: BIT_MARK/BIT_SPACE pairs for bit index 0..31, with space length chosen by the latched bit. After bit 31's space, go to STOP_MARK, then GAP, then IDLE.
- Marks: with `MODULATE` = 1, `ir_output` follows the carrier, high for the first `CARRIER_HIGH` cycles of each `CARRIER_PERIOD`. The carrier phase restarts at 0 at the start of every mark, so the first mark cycle is high. With `MODULATE` = 0, `ir_output` = 1 throughout marks. Spaces and GAP: `ir_output` = 0.
- `valid` while `ready` = 0 is ignored and the command is dropped, not queued. Changes to `cmd` after acceptance have no effect on the frame.
- Frame length in units = 89 + 2·(number of ones in `cmd`); gap excluded.
- Counters: cycle-in-unit counter 0..`UNIT_CYC`−1, unit-in-phase counter, bit index 0..31, carrier counter 0..`CARRIER_PERIOD`−1. Each wraps to 0 at its terminal count. No free-running carrier.
- Reset (at any time, including mid-frame) aborts the frame. On the next edge: IDLE, `ready` = 1, `ir_output` = 0, `done` = 0, all counters 0.

## Timing
- Reset values: `ready` = 1, `ir_output` = 0, `done` = 0.
- Accept edge T (`valid && ready` sampled high). At T+1: `ready` = 0 and the first `ir_output` leader cycle is driven.
- Each phase lasts exactly (units × `UNIT_CYC`) cycles, with no extra cycles at phase boundaries.
- The last GAP cycle is at T + (89 + 2k + `GAP_UNITS`)·`UNIT_CYC`. On the following cycle, `ready` = 1 and `done` = 1 for exactly one cycle.
- A command presented in the same cycle `ready` rises is accepted; back-to-back frames are therefore separated by exactly the gap.
- `rst` asserted together with `valid`: reset wins, and nothing is accepted.

## Structure
- Shared package `nec_pkg`: state enum; unit constants LEAD_MARK_UNITS = 16, LEAD_SPACE_UNITS = 8, BIT_MARK_UNITS = 1, ZERO_SPACE_UNITS = 1, ONE_SPACE_UNITS = 3, STOP_MARK_UNITS = 1, FRAME_BITS = 32.
- One sub-module, `ir_carrier_gen`: carrier counter plus high-window compare, with a `restart` input asserted at mark start and an `enable` input for mark gating. The FSM, counters and shift register stay in `nec_tx`.

## Test plan
Bench parameters: `UNIT_CYC` = 4, `CARRIER_PERIOD` = 3, `CARRIER_HIGH` = 1, `GAP_UNITS` = 72.

- Reset, then idle 20 cycles -> `ready` = 1, `ir_output` = 0, `done` = 0 throughout.
- `cmd` = 32'h9D620707 (14 ones), one-cycle `valid`, `MODULATE` = 0 -> leader high for 64 cycles and low for 32. Decoded pulse distances give bits LSB-first equal to 0x9D620707. Stop mark is 4 cycles. `ready` is low for 468 + 288 = 756 cycles, then `done` pulses once.
- Same command with `MODULATE` = 1 -> inside every mark, `ir_output` pattern is 1,0,0 repeating, starting with 1 at each mark start. No high output in any space.
- `valid` pulsed 100 cycles into a frame with a different `cmd` -> ignored. The waveform is identical to the single-command case, and no second frame follows.
- `valid` held high with `cmd` = 32'h0 -> the second frame starts exactly on the cycle `ready` rises. Frame length is 89 units (356 cycles).
- `rst` pulsed during bit 10's space -> the next cycle shows `ready` = 1 and `ir_output` = 0, with no `done`. A new command then produces a full, correct frame.
